fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of mem_system's read port and downstream of decode redirects.
- Generates word-aligned PCs and issues one read per cycle to the single-cycle memory.
- Captures returned words with their PC into a small instruction queue.
- Presents them to decode with a valid/ready handshake, and handles branch redirect flushes.

Parameters:
RESET_PC, 32'h0000_2000, PC loaded on reset; low 2 bits forced to 0
DEPTH, 4, instruction queue entries (power of 2, >=2)

Ports:
clk  input  1  single clock; all state changes on posedge
rst_n  input  1  synchronous, active-low reset
mem_addr  output  32  read address to memory, always word-aligned
mem_wr  output  1  tied 0 (fetch never writes)
mem_data_in  output  32  tied 0
mem_data_out  input  32  memory read data for address presented previous cycle
mem_data_valid  input  1  mem_data_out is valid this cycle
branch_valid  input  1  redirect request from downstream
branch_target  input  32  redirect PC; bits [1:0] ignored
dec_ready  input  1  decode accepts head entry this cycle
dec_valid  output  1  queue head valid
dec_instr  output  32  head instruction word
dec_pc  output  32  head instruction PC
fetch_issue  output  1  a new read is issued this cycle (debug/perf)

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, queue emptied, inflight=0, state=BOOT.
  - dec_valid=0, dec_instr=0, dec_pc=0, fetch_issue=0, mem_addr=RESET_PC.
  - Reset mid-operation discards the queue and the in-flight read; the late memory response is ignored.
- FSM states BOOT, RUN, WAIT:
  - BOOT: no issue; next state RUN.
  - RUN: issue when allowed; go to WAIT if inflight=1 and mem_data_valid=0.
  - WAIT: mem_addr held at inflight_pc, no new issue; return to RUN on mem_data_valid=1 (the response is pushed that cycle).
- Issue (RUN):
  - Allowed when branch_valid=0 and occupancy (count+inflight) < DEPTH, or occupancy==DEPTH with a pop this cycle.
  - On issue: mem_addr=pc, fetch_issue=1; at the edge, inflight<=1, inflight_pc<=pc, pc<=pc+4.
  - PC wraps 32'hFFFF_FFFC -> 0.
  - When not issuing, mem_addr=pc (harmless read) and the response is not tracked.
- Response:
  - If inflight=1 and mem_data_valid=1 and branch_valid=0: push {inflight_pc, mem_data_out}.
  - inflight clears unless a new issue occurs the same cycle.
  - Single-cycle memory therefore sustains 1 instruction/cycle.
- Queue:
  - FIFO of DEPTH entries; dec_valid = count!=0; dec_instr/dec_pc come from the head, driven from registers.
  - Pop when dec_valid && dec_ready && !branch_valid.
  - Push and pop in the same cycle leave count unchanged.
  - Push while full is impossible by the issue rule; an assertion fires if it occurs.
  - Pop while empty is ignored.
- Latency: instruction issued in cycle N is visible on dec_valid in cycle N+2 (memory 1 cycle, queue 1 cycle).
- Redirect, branch_valid=1 in cycle t (highest priority):
  - dec_valid forced 0 in cycle t.
  - No issue, no push, no pop.
  - At the edge: queue cleared, inflight<=0, pc<=branch_target&~3, state<=RUN.
  - Any response arriving in cycle t or t+1 for the pre-redirect address is dropped; the target is issued in cycle t+1.
  - Back-to-back redirects: the last one wins.
- dec_instr/dec_pc are held stable while dec_valid=1 and dec_ready=0.

Test Plan:
- Reset release, memory preloaded with word at 0x2000=0xA000_0001, 0x2004=0xA000_0002, dec_ready=1 -> mem_addr sequence 0x2000, 0x2004, 0x2008…; dec_valid first high 3 edges after rst_n=1; dec_pc/dec_instr = 0x2000/0xA000_0001, then 0x2004/0xA000_0002 on consecutive cycles.
- dec_ready=0 from reset -> exactly DEPTH=4 issues (0x2000–0x200C); fetch_issue stays 0 afterwards; head holds 0x2000. Raise dec_ready -> 4 pops, issue resumes at 0x2010 with no gaps or duplicates.
- Redirect branch_valid=1, target=0x2103 while queue holds 3 entries and one in flight -> dec_valid=0 next cycle; queue empty; next issued mem_addr=0x2100; first decoded pc=0x2100; no pre-redirect PC appears.
- mem_data_valid forced 0 for 3 cycles after issuing 0x2008 -> state WAIT; mem_addr stays 0x2008; no push; on valid, entry 0x2008 is pushed and issue resumes at 0x200C.
- rst_n asserted for 1 cycle mid-stream with an in-flight read -> dec_valid=0 after the edge; mem_addr=0x2000; the old response is not enqueued.
- branch_target=0xFFFF_FFFC -> issues 0xFFFF_FFFC then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues one word-aligned read per
//               cycle to a single-cycle memory, queues returned words with
//               their PC and hands them to decode over valid/ready. Branch
//               redirects flush the queue and the outstanding read.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_data_valid,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_issue
);

  localparam int unsigned     PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [31:0]     RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];

  logic [CNT_W-1:0]  occ;
  logic              not_empty;
  logic              issue;
  logic              push;
  logic              pop;

  // Branch target low bits are don't-care; fold them into a sink.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // Fetch never writes memory.
  assign mem_wr      = 1'b0;
  assign mem_data_in = 32'h0;

  // Queue head drives decode straight from storage; a redirect masks valid.
  assign dec_valid   = not_empty && !branch_valid;
  assign dec_instr   = instr_mem_q[rd_ptr_q];
  assign dec_pc      = pc_mem_q[rd_ptr_q];
  assign fetch_issue = issue;

  // Next-state, issue decision, push/pop and memory address selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    issue         = 1'b0;
    mem_addr      = pc_q;

    // Occupancy counts the outstanding read so the queue can never overflow.
    occ       = count_q + {{PTR_W{1'b0}}, inflight_q};
    not_empty = (count_q != '0);
    pop       = not_empty && dec_ready && !branch_valid;
    push      = inflight_q && mem_data_valid && !branch_valid;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (inflight_q && !mem_data_valid) begin
          // Response is late: keep presenting the outstanding address.
          mem_addr = inflight_pc_q;
          state_d  = WAIT;
        end else if (!branch_valid &&
                     ((occ < DEPTH_CNT) || ((occ == DEPTH_CNT) && pop))) begin
          issue = 1'b1;
        end
      end
      WAIT: begin
        mem_addr = inflight_pc_q;
        if (mem_data_valid) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (inflight_q && mem_data_valid) begin
      inflight_d = 1'b0;
    end
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    // Redirect overrides everything: flush queue and outstanding read.
    if (branch_valid) begin
      inflight_d = 1'b0;
      pc_d       = {branch_target[31:2], 2'b00};
      count_d    = '0;
      state_d    = RUN;
    end
  end

  // Control state, PC tracking and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC_AL;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC_AL;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      if (branch_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Queue storage; cleared on reset so decode outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[PTR_W'(i)] <= '0;
        pc_mem_q[PTR_W'(i)]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= mem_data_out;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // The issue rule must make a push into a full queue impossible.
  full_push_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == DEPTH_CNT)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               single-cycle memory model whose valid can be withheld.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_vld;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_issue;

  logic [31:0] r_addr = 32'h0;
  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_2000), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_wr        (mem_wr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_data_valid(mem_vld),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .dec_ready     (dec_ready),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .fetch_issue   (fetch_issue)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x2000 -> 0xA000_0001, 0x2004 -> 0xA000_0002, ...
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2) - 32'h0000_07FF;
  endfunction

  // Single-cycle memory: data for the address presented last cycle.
  always @(posedge clk) r_addr <= mem_addr;
  assign mem_data_out = word(r_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then release; returns inside cycle 0 (BOOT).
  task automatic do_reset(input logic ready);
    rst_n = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
    mem_vld = 1'b1; dec_ready = ready;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks += 7;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b exp 0", dec_valid); end
    if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr: got %h exp 0", dec_instr); end
    if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc: got %h exp 0", dec_pc); end
    if (fetch_issue !== 1'b0) begin errors++; $display("FAIL reset_fetch_issue: got %b exp 0", fetch_issue); end
    if (mem_addr !== 32'h2000) begin errors++; $display("FAIL reset_mem_addr: got %h exp 00002000", mem_addr); end
    if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b exp 0", mem_wr); end
    if (mem_data_in !== 32'h0) begin errors++; $display("FAIL reset_mem_data_in: got %h exp 0", mem_data_in); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    do_reset(1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick(); #1;
      ea = 32'h2000 + 32'(4 * (c - 1));
      checks += 3;
      if (mem_addr !== ea) begin errors++; $display("FAIL stream_addr c%0d: got %h exp %h", c, mem_addr, ea); end
      if (fetch_issue !== 1'b1) begin errors++; $display("FAIL stream_issue c%0d: got %b exp 1", c, fetch_issue); end
      if (dec_valid !== (c >= 3)) begin errors++; $display("FAIL stream_valid c%0d: got %b exp %b", c, dec_valid, (c >= 3)); end
      if (c >= 3) begin
        ep = 32'h2000 + 32'(4 * (c - 3));
        checks += 2;
        if (dec_pc !== ep) begin errors++; $display("FAIL stream_pc c%0d: got %h exp %h", c, dec_pc, ep); end
        if (dec_instr !== word(ep)) begin errors++; $display("FAIL stream_instr c%0d: got %h exp %h", c, dec_instr, word(ep)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, ep;
    do_reset(1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      checks++;
      if (fetch_issue !== (c <= 4)) begin errors++; $display("FAIL bp_issue c%0d: got %b exp %b", c, fetch_issue, (c <= 4)); end
      if (c <= 4) begin
        ea = 32'h2000 + 32'(4 * (c - 1));
        checks++;
        if (mem_addr !== ea) begin errors++; $display("FAIL bp_addr c%0d: got %h exp %h", c, mem_addr, ea); end
      end
      if (c >= 3) begin
        checks += 2;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b exp 1", c, dec_valid); end
        if (dec_pc !== 32'h2000) begin errors++; $display("FAIL bp_hold_pc c%0d: got %h exp 00002000", c, dec_pc); end
      end
    end
    for (int c = 9; c <= 16; c++) begin
      tick();
      dec_ready = 1'b1;
      #1;
      ea = 32'h2010 + 32'(4 * (c - 9));
      ep = 32'h2000 + 32'(4 * (c - 9));
      checks += 4;
      if (fetch_issue !== 1'b1) begin errors++; $display("FAIL bp_resume_issue c%0d: got %b exp 1", c, fetch_issue); end
      if (mem_addr !== ea) begin errors++; $display("FAIL bp_resume_addr c%0d: got %h exp %h", c, mem_addr, ea); end
      if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid c%0d: got %b exp 1", c, dec_valid); end
      if (dec_pc !== ep) begin errors++; $display("FAIL bp_drain_pc c%0d: got %h exp %h", c, dec_pc, ep); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] ep;
    do_reset(1'b0);
    for (int c = 1; c <= 4; c++) tick();
    // Cycle 5: three entries queued, 0x200C in flight.
    tick();
    branch_valid = 1'b1; branch_target = 32'h0000_2103;
    #1;
    checks += 2;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_forced: got %b exp 0", dec_valid); end
    if (fetch_issue !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b exp 0", fetch_issue); end
    tick();
    branch_valid = 1'b0; dec_ready = 1'b1;
    #1;
    checks += 3;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed: got %b exp 0", dec_valid); end
    if (mem_addr !== 32'h2100) begin errors++; $display("FAIL redir_target_addr: got %h exp 00002100", mem_addr); end
    if (fetch_issue !== 1'b1) begin errors++; $display("FAIL redir_target_issue: got %b exp 1", fetch_issue); end
    tick(); #1;
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_drop: got %b exp 0", dec_valid); end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      ep = 32'h2100 + 32'(4 * k);
      checks += 2;
      if (dec_valid !== 1'b1) begin errors++; $display("FAIL redir_dec_valid k%0d: got %b exp 1", k, dec_valid); end
      if (dec_pc !== ep) begin errors++; $display("FAIL redir_dec_pc k%0d: got %h exp %h", k, dec_pc, ep); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    tick(); tick();
    tick();
    branch_valid = 1'b1; branch_target = 32'h0000_3000;
    #1;
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_forced: got %b exp 0", dec_valid); end
    tick();
    branch_target = 32'h0000_2201;
    #1;
    checks++;
    if (fetch_issue !== 1'b0) begin errors++; $display("FAIL b2b_no_issue: got %b exp 0", fetch_issue); end
    tick();
    branch_valid = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 32'h2200) begin errors++; $display("FAIL b2b_last_wins: got %h exp 00002200", mem_addr); end
    tick(); tick(); #1;
    checks += 2;
    if (dec_pc !== 32'h2200) begin errors++; $display("FAIL b2b_dec_pc: got %h exp 00002200", dec_pc); end
    if (dec_instr !== word(32'h2200)) begin errors++; $display("FAIL b2b_dec_instr: got %h exp %h", dec_instr, word(32'h2200)); end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      mem_vld = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 7) begin
        checks++;
        if (fetch_issue !== 1'b0) begin errors++; $display("FAIL stall_no_issue c%0d: got %b exp 0", c, fetch_issue); end
      end
      if (c >= 5 && c <= 7) begin
        checks += 2;
        if (mem_addr !== 32'h2008) begin errors++; $display("FAIL stall_addr_hold c%0d: got %h exp 00002008", c, mem_addr); end
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL stall_no_push c%0d: got %b exp 0", c, dec_valid); end
      end
      if (c == 8) begin
        checks += 4;
        if (dec_pc !== 32'h2008) begin errors++; $display("FAIL stall_pushed_pc: got %h exp 00002008", dec_pc); end
        if (dec_instr !== word(32'h2008)) begin errors++; $display("FAIL stall_pushed_instr: got %h exp %h", dec_instr, word(32'h2008)); end
        if (mem_addr !== 32'h200C) begin errors++; $display("FAIL stall_resume_addr: got %h exp 0000200c", mem_addr); end
        if (fetch_issue !== 1'b1) begin errors++; $display("FAIL stall_resume_issue: got %b exp 1", fetch_issue); end
      end
      if (c == 10) begin
        checks++;
        if (dec_pc !== 32'h200C) begin errors++; $display("FAIL stall_next_pc: got %h exp 0000200c", dec_pc); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    tick(); tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; dec_ready = 1'b1;
    #1;
    checks += 3;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b exp 0", dec_valid); end
    if (mem_addr !== 32'h2000) begin errors++; $display("FAIL mrst_addr: got %h exp 00002000", mem_addr); end
    if (fetch_issue !== 1'b0) begin errors++; $display("FAIL mrst_issue: got %b exp 0", fetch_issue); end
    tick(); #1;
    checks++;
    if (mem_addr !== 32'h2000) begin errors++; $display("FAIL mrst_first_issue: got %h exp 00002000", mem_addr); end
    tick(); #1;
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL mrst_old_dropped: got %b exp 0", dec_valid); end
    tick(); #1;
    checks += 2;
    if (dec_valid !== 1'b1) begin errors++; $display("FAIL mrst_dec_valid: got %b exp 1", dec_valid); end
    if (dec_pc !== 32'h2000) begin errors++; $display("FAIL mrst_dec_pc: got %h exp 00002000", dec_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    tick();
    tick();
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFFF;
    #1;
    tick();
    branch_valid = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_top: got %h exp fffffffc", mem_addr); end
    tick(); #1;
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr_zero: got %h exp 00000000", mem_addr); end
    tick(); #1;
    checks++;
    if (dec_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_dec_top: got %h exp fffffffc", dec_pc); end
    tick(); #1;
    checks += 2;
    if (dec_pc !== 32'h0) begin errors++; $display("FAIL wrap_dec_zero: got %h exp 00000000", dec_pc); end
    if (dec_instr !== word(32'h0)) begin errors++; $display("FAIL wrap_dec_instr: got %h exp %h", dec_instr, word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
